// File: rtl/lsu_ctrl_if.sv
// Request/response and data_mem signals of the load/store control unit.
// The slave modport is the unit's own view; the master modport is the requester/memory side.
interface lsu_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_err, resp_rdata,
           mem_addr, mem_read, mem_write, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_err, resp_rdata,
           mem_addr, mem_read, mem_write, mem_wdata
  );
endinterface

// File: rtl/lsu_ctrl.sv
// RV32I load/store control: maps byte/half/word accesses onto a word-only data memory,
// using read-modify-write for sub-word stores and flagging illegal/misaligned requests.
module lsu_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  lsu_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, RD, CAP, WR} state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [2:0]          funct3_q, funct3_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wbuf_q, wbuf_d;
  logic                resp_valid_q, resp_valid_d;
  logic                resp_err_q, resp_err_d;
  logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;

  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    if (we) return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
    return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
           (f3 == 3'b100) || (f3 == 3'b101);
  endfunction

  // f3[1:0] encodes the access size for every legal code: 00 byte, 01 half, 10 word
  function automatic logic f3_aligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b01:   return (off[0] == 1'b0);
      2'b10:   return (off == 2'b00);
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] w);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    case (off)
      2'b00:   b = w[7:0];
      2'b01:   b = w[15:8];
      2'b10:   b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] w, input logic [31:0] d);
    logic [31:0] r;
    r = w;
    if (f3[1:0] == 2'b00) begin
      case (off)
        2'b00:   r[7:0]   = d[7:0];
        2'b01:   r[15:8]  = d[7:0];
        2'b10:   r[23:16] = d[7:0];
        default: r[31:24] = d[7:0];
      endcase
    end else if (off[1]) begin
      r[31:16] = d[15:0];
    end else begin
      r[15:0] = d[15:0];
    end
    return r;
  endfunction

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    funct3_d     = funct3_q;
    we_d         = we_q;
    wbuf_d       = wbuf_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = '0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          addr_d   = bus.req_addr;
          wdata_d  = bus.req_wdata;
          funct3_d = bus.req_funct3;
          we_d     = bus.req_we;
          if (!f3_legal(bus.req_we, bus.req_funct3) ||
              !f3_aligned(bus.req_funct3, bus.req_addr[1:0])) begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else if (bus.req_we && (bus.req_funct3 == 3'b010)) begin
            wbuf_d  = bus.req_wdata;
            state_d = WR;
          end else begin
            state_d = RD;
          end
        end
      end
      RD:  state_d = CAP;
      CAP: begin
        if (we_q) begin
          wbuf_d  = store_merge(funct3_q, addr_q[1:0], bus.mem_rdata, wdata_q);
          state_d = WR;
        end else begin
          resp_valid_d = 1'b1;
          resp_rdata_d = load_ext(funct3_q, addr_q[1:0], bus.mem_rdata);
          state_d      = IDLE;
        end
      end
      default: begin
        resp_valid_d = 1'b1;
        state_d      = IDLE;
      end
    endcase
  end

  // State register; reset clears all latched request and response state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      funct3_q     <= '0;
      we_q         <= 1'b0;
      wbuf_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      funct3_q     <= funct3_d;
      we_q         <= we_d;
      wbuf_q       <= wbuf_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.mem_addr   = {addr_q[DATA_W-1:2], 2'b00};
  assign bus.mem_read   = (state_q == RD) && !rst;
  assign bus.mem_write  = (state_q == WR) && !rst;
  assign bus.mem_wdata  = wbuf_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a word-wide behavioural data memory.
module tb_lsu_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lsu_ctrl_if bus ();
  lsu_ctrl #(.DATA_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [31:0] mem [0:511];
  int rd_cnt = 0;
  int wr_cnt = 0;
  int checks = 0;
  int failures = 0;

  always @(posedge clk) begin
    if (bus.mem_read) begin
      bus.mem_rdata <= mem[bus.mem_addr[10:2]];
      rd_cnt <= rd_cnt + 1;
    end
    if (bus.mem_write) begin
      mem[bus.mem_addr[10:2]] <= bus.mem_wdata;
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  int          lat, rd_cyc, wr_cyc;
  logic [31:0] r_data, wr_data, wr_addr, rd_addr;
  logic        r_err;

  // Issue one request and record per-cycle observations, cycle k = k-th cycle after accept
  task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wdata);
    lat = 0; rd_cyc = 0; wr_cyc = 0;
    r_data = 32'hx; r_err = 1'bx; wr_data = 32'hx; wr_addr = 32'hx; rd_addr = 32'hx;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (bus.mem_read && rd_cyc == 0) begin rd_cyc = k; rd_addr = bus.mem_addr; end
      if (bus.mem_write && wr_cyc == 0) begin
        wr_cyc = k; wr_data = bus.mem_wdata; wr_addr = bus.mem_addr;
      end
      if (bus.resp_valid) begin
        lat = k; r_data = bus.resp_rdata; r_err = bus.resp_err;
        break;
      end
    end
  endtask

  int rc0, wc0;

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 32'h0;
    mem[1000 >> 2] = 32'h00000008;
    mem[1008 >> 2] = 32'h00000038;
    mem[1032 >> 2] = 32'h000000B3;
    bus.mem_rdata  = 32'h0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mem_read", {31'd0, bus.mem_read}, 32'd0);
    rst = 1'b0;
    check("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("rst_resp_err", {31'd0, bus.resp_err}, 32'd0);
    check("rst_resp_rdata", bus.resp_rdata, 32'd0);
    check("rst_ready", {31'd0, bus.req_ready}, 32'd1);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_mem_write", {31'd0, bus.mem_write}, 32'd0);

    xact(1'b0, 3'b010, 32'd1008, 32'h0);
    check("lw_rd_cyc", rd_cyc, 1);
    check("lw_rd_addr", rd_addr, 32'd1008);
    check("lw_lat", lat, 3);
    check("lw_data", r_data, 32'h00000038);
    check("lw_err", {31'd0, r_err}, 32'd0);

    xact(1'b0, 3'b000, 32'd1032, 32'h0);
    check("lb_data", r_data, 32'hFFFFFFB3);
    check("lb_lat", lat, 3);
    xact(1'b0, 3'b100, 32'd1032, 32'h0);
    check("lbu_data", r_data, 32'h000000B3);
    xact(1'b0, 3'b101, 32'd1034, 32'h0);
    check("lhu_data", r_data, 32'h00000000);

    xact(1'b1, 3'b000, 32'd1033, 32'h123456AA);
    check("sb_rd_cyc", rd_cyc, 1);
    check("sb_wr_cyc", wr_cyc, 3);
    check("sb_wdata", wr_data, 32'h0000AAB3);
    check("sb_waddr", wr_addr, 32'd1032);
    check("sb_lat", lat, 4);
    check("sb_rdata", r_data, 32'd0);
    xact(1'b0, 3'b000, 32'd1033, 32'h0);
    check("lb_after_sb", r_data, 32'hFFFFFFAA);
    xact(1'b0, 3'b001, 32'd1032, 32'h0);
    check("lh_after_sb", r_data, 32'hFFFFAAB3);

    xact(1'b1, 3'b010, 32'd1016, 32'hDEADBEEF);
    check("sw_wr_cyc", wr_cyc, 1);
    check("sw_wdata", wr_data, 32'hDEADBEEF);
    check("sw_rd_cyc", rd_cyc, 0);
    check("sw_lat", lat, 2);
    xact(1'b0, 3'b010, 32'd1016, 32'h0);
    check("lw_after_sw", r_data, 32'hDEADBEEF);
    xact(1'b0, 3'b001, 32'd1018, 32'h0);
    check("lh_hi", r_data, 32'hFFFFDEAD);
    xact(1'b0, 3'b101, 32'd1018, 32'h0);
    check("lhu_hi", r_data, 32'h0000DEAD);
    xact(1'b0, 3'b000, 32'd1019, 32'h0);
    check("lb_b3", r_data, 32'hFFFFFFDE);

    xact(1'b1, 3'b001, 32'd1022, 32'h0000BEEF);
    check("sh_lat", lat, 4);
    check("sh_wdata", wr_data, 32'hBEEF0000);

    rc0 = rd_cnt; wc0 = wr_cnt;
    xact(1'b0, 3'b010, 32'd1002, 32'h0);
    check("mis_lw_lat", lat, 1);
    check("mis_lw_err", {31'd0, r_err}, 32'd1);
    check("mis_lw_rdata", r_data, 32'd0);
    xact(1'b0, 3'b011, 32'd1000, 32'h0);
    check("ill_ld_lat", lat, 1);
    check("ill_ld_err", {31'd0, r_err}, 32'd1);
    xact(1'b1, 3'b001, 32'd1001, 32'h5555);
    check("mis_sh_err", {31'd0, r_err}, 32'd1);
    xact(1'b1, 3'b100, 32'd1000, 32'h5555);
    check("ill_st_err", {31'd0, r_err}, 32'd1);
    repeat (2) @(negedge clk);
    check("err_no_read", rd_cnt, rc0);
    check("err_no_write", wr_cnt, wc0);

    wc0 = wr_cnt;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b001;
    bus.req_addr = 32'd1000; bus.req_wdata = 32'h00001234;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    check("rstrd_mem_read", {31'd0, bus.mem_read}, 32'd1);
    rst = 1'b1;
    #1 check("rstrd_forced_low", {31'd0, bus.mem_read}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rstrd_ready", {31'd0, bus.req_ready}, 32'd1);
    check("rstrd_resp", {31'd0, bus.resp_valid}, 32'd0);
    repeat (6) @(negedge clk);
    check("rstrd_no_write", wr_cnt, wc0);
    check("rstrd_mem", mem[1000 >> 2], 32'h00000008);
    check("rstrd_ready_late", {31'd0, bus.req_ready}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
Load/store control unit directly upstream of data_mem; sits between the MEM-stage request and the word-wide data memory.
- Converts RV32I byte, halfword and word loads and stores into whole-word memory accesses.
- Loads: extracts the addressed lane and sign- or zero-extends it.
- Sub-word stores: read-modify-write, because data_mem only writes full words.
- Detects misaligned accesses and illegal funct3 codes and reports them without touching memory.

Parameters:
width, 32, data and address width (only 32 is supported).

Ports:
clk  input  1  clock; all state changes on the rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  high only in IDLE; request accepted on an edge where req_valid && req_ready
req_we  input  1  1 = store, 0 = load
req_funct3  input  3  RV32I load/store funct3
req_addr  input  width  byte address
req_wdata  input  width  store data; lane taken from its low bits
resp_valid  output  1  one-cycle completion pulse
resp_err  output  1  qualifies resp_valid: misaligned access or illegal funct3
resp_rdata  output  width  extended load result; 0 for stores and errors
mem_addr  output  width  word-aligned byte address to data_mem: {lat_addr[31:2],2'b00}
mem_read  output  1  data_mem read strobe
mem_write  output  1  data_mem write strobe
mem_wdata  output  width  word to write
mem_rdata  input  width  data_mem read data; valid in the cycle after mem_read is high

Behaviour:
- Reset (sync, rst=1 at the edge):
  - state=IDLE; resp_valid=0, resp_err=0, resp_rdata=0.
  - Latched request registers and write buffer cleared to 0.
  - mem_read and mem_write are forced low combinationally while rst=1.
  - An in-flight operation is aborted; no write is issued after the reset edge.
- funct3 decode:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Every other code is illegal and produces an error.
- Alignment:
  - Halfword needs addr[0]=0; word needs addr[1:0]=00; byte accesses are always aligned.
  - Lanes are little-endian and selected by addr[1:0].
- States: IDLE, RD, CAP, WR. Memory strobes are decoded from state (RD gives mem_read=1, WR gives mem_write=1, otherwise both 0).
- IDLE:
  - req_ready=1.
  - On accept, latch addr, wdata, funct3 and we.
  - Illegal or misaligned: stay in IDLE; next cycle resp_valid=1, resp_err=1, resp_rdata=0; no memory access.
  - SW: go to WR with wbuf = req_wdata.
  - Load, SB or SH: go to RD.
- RD: mem_read=1; next state CAP.
- CAP (mem_rdata valid this cycle):
  - Load: resp_rdata <= extended lane; resp_valid=1 in the next cycle; go to IDLE.
  - Store: wbuf <= mem_rdata with the addressed byte/halfword replaced by wdata[7:0] or [15:0]; go to WR.
- WR: mem_write=1, mem_wdata=wbuf; go to IDLE; resp_valid=1 in the next cycle with resp_rdata=0.
- Latency, counted from the accept edge T0 (cycle count until resp_valid is high):
  - Error: 1 cycle.
  - SW: 2 cycles.
  - Loads: 3 cycles.
  - SB/SH: 4 cycles.
  - A new request can be accepted in the same cycle resp_valid is high, because the state is already IDLE.
- resp_valid: lasts exactly one cycle; there is no back-pressure on the response.
- Request inputs: ignored outside IDLE.
- Extension:
  - LB/LH replicate bit 7/15 of the lane.
  - LBU/LHU zero-fill.
  - LW passes the word through.

Test Plan:
- Reset, then LW addr 1008 with mem[1008]=0x00000038 -> mem_read in T1 with mem_addr=1008; resp_valid in T3 with resp_rdata=0x00000038 and resp_err=0.
- LB addr 1032 with mem[1032]=0x000000B3 -> resp_rdata=0xFFFFFFB3; LBU at the same address -> 0x000000B3; LHU addr 1034 -> 0x00000000.
- SB addr 1033, wdata=0x123456AA, mem[1032]=0x000000B3 -> RD in T1, WR in T3 with mem_wdata=0x0000AAB3 and mem_addr=1032; resp_valid in T4.
- SW addr 1016, wdata=0xDEADBEEF -> mem_write in T1 with mem_wdata=0xDEADBEEF; resp_valid in T2; following LW 1016 returns 0xDEADBEEF.
- LW addr 1002, and separately funct3=011 load -> resp_valid and resp_err in T1, resp_rdata=0; mem_read and mem_write never asserted.
- SH addr 1000 with rst asserted during RD -> state IDLE after that edge; mem_write never asserted; mem[1000] still 0x00000008; req_ready=1.
